serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle, parametrised N-bit subtractor computing a − b − bin, DIGIT bits per clock, LSB digit first, with a registered borrow between digits. It succeeds the single-bit combinational full subtractor cell: same arithmetic, now word-wide, with start/done handshake and signed-overflow reporting. It sits in the arithmetic datapath wherever a small-area subtract is acceptable in exchange for latency.

## Interface
- WIDTH, 8: operand/result width in bits; ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH (elaboration error otherwise).
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when ready (state IDLE or DONE).
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while state RUN.
- done  output  1  one-cycle pulse: results valid and newly updated.
- diff  output  WIDTH  a − b − bin mod 2^WIDTH; held until the next completion.
- bout  output  1  final borrow-out (1 when unsigned a < b + bin).
- ovf  output  1  signed overflow: (a[MSB] ≠ b[MSB]) and (diff[MSB] ≠ a[MSB]).

## Operation
- K = WIDTH/DIGIT digit steps per operation.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → load a, b into shift registers, borrow reg ← bin, step counter ← 0, go RUN. start=0 → stay.
- RUN: each cycle subtract the low DIGIT bits of a/b with borrow reg; shift result digit into the diff accumulator from the top; borrow reg ← digit borrow-out; counter +1. start is ignored.
- After step K−1: diff, bout, ovf outputs update together; go DONE.
- DONE (one cycle): done=1. start=1 → accept new operands exactly as in IDLE, go RUN (back-to-back). start=0 → IDLE.
- Operands changing after capture have no effect on the operation in flight.
- Output registers diff/bout/ovf change only at completion; the internal accumulator is separate and never exposed mid-operation.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter and borrow reg 0. Applies mid-operation: the operation in flight is abandoned and no done is issued.
- Latency: start sampled at edge n → done=1 and new results visible in the cycle after edge n+K (WIDTH=8, DIGIT=1: K=8; DIGIT=4: K=2; DIGIT=WIDTH: K=1).
- Throughput with start held high: one result per K+1 cycles.
- busy=1 in exactly K consecutive cycles per operation; done never coincides with busy.
- start asserted together with rst_n=0: reset wins, start is lost.

## Structure
- Shared package: state enum (IDLE, RUN, DONE); function or localparam for K and the counter width $clog2(K) (minimum 1).
- Sub-module sub_digit: combinational DIGIT-bit ripple-borrow chain of full-subtractor cells (inputs a, b, bin; outputs diff, bout). Instantiated once; all sequencing stays in serial_subtractor.

## Test plan
- WIDTH=8, DIGIT=1: a=8'h5A, b=8'h3C, bin=0 → done 8 cycles after start, diff=8'h1E, bout=0, ovf=0.
- a=8'h00, b=8'h01, bin=0 → diff=8'hFF, bout=1, ovf=0. Then a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0, ovf=1.
- Borrow-in: a=8'h10, b=8'h0F, bin=1 → diff=8'h00, bout=0, ovf=0. Then a=8'h00, b=8'h00, bin=1 → diff=8'hFF, bout=1.
- Handshake: start pulsed again at RUN cycle 3 with different operands → ignored, single done with first result. start held high through DONE → second operation begins immediately, done pulses 9 cycles apart.
- Reset mid-op: rst_n=0 at RUN cycle 4 → next cycle all outputs 0, state IDLE, no done. Fresh start after release completes normally.
- DIGIT=4 and DIGIT=8 builds: same vectors as the first scenario → identical results with done after 2 and 1 cycles; a random-vector sweep (≥1000) matches a − b − bin reference model on diff, bout and ovf.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: sequencing states and
// helpers that derive the step count and step-counter width from the build
// parameters.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps needed to cover the whole word.
  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter width; a single-step build still keeps a 1-bit counter.
  function automatic int calc_cnt_w(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit slice: a ripple-borrow chain of full-subtractor
// cells computing a - b - bin for one digit of the operands.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  // brw[i] is the borrow into bit i; brw[DIGIT] leaves the slice.
  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ brw[i];
    // Borrow out when b exceeds a, or when they are equal and a borrow
    // arrives from below.
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial N-bit subtractor: diff = a - b - bin, DIGIT bits per clock,
// LSB digit first, borrow carried between digits in a register. Results,
// borrow-out and signed overflow update together at completion only.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int K  = calc_steps(WIDTH, DIGIT);
  localparam int CW = calc_cnt_w(K);
  localparam logic [CW-1:0] LAST_STEP = CW'(K - 1);

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [DIGIT-1:0] dig_diff_s;
  logic             dig_bout_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] b_next_s;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .a    (a_sh_r[DIGIT-1:0]),
    .b    (b_sh_r[DIGIT-1:0]),
    .bin  (borrow_r),
    .diff (dig_diff_s),
    .bout (dig_bout_s)
  );

  // Operands drain from the bottom; each new result digit enters the
  // accumulator at the top so that after K steps it sits LSB-aligned.
  assign a_next_s   = a_sh_r >> DIGIT;
  assign b_next_s   = b_sh_r >> DIGIT;
  assign acc_next_s = (acc_r >> DIGIT) | (WIDTH'(dig_diff_s) << (WIDTH - DIGIT));

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and datapath strobes; start is only honoured when idle
  // or in the completion cycle, which gives back-to-back operation.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_STEP) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand capture, per-digit stepping and result commit at the final step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (load_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      acc_r    <= {WIDTH{1'b0}};
      borrow_r <= bin;
      cnt_r    <= {CW{1'b0}};
      a_msb_r  <= a[WIDTH-1];
      b_msb_r  <= b[WIDTH-1];
    end else if (step_s) begin
      a_sh_r   <= a_next_s;
      b_sh_r   <= b_next_s;
      acc_r    <= acc_next_s;
      borrow_r <= dig_bout_s;
      cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      if (last_s) begin
        diff_r <= acc_next_s;
        bout_r <= dig_bout_s;
        // Overflow only when operand signs differ and the result sign
        // departs from the minuend sign.
        ovf_r  <= (a_msb_r ^ b_msb_r) & (acc_next_s[WIDTH-1] ^ a_msb_r);
      end
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three builds (DIGIT=1, 4, 8)
// share operands and reset, each with its own start. Directed table,
// handshake and reset sequences, then a random sweep against a model.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   start_v;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   bout_v;
  logic [2:0]   ovf_v;
  logic [W-1:0] diff_v [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b), .bin(bin),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .bout(bout_v[0]), .ovf(ovf_v[0]));
  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b), .bin(bin),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .bout(bout_v[1]), .ovf(ovf_v[1]));
  serial_subtractor #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b), .bin(bin),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .bout(bout_v[2]), .ovf(ovf_v[2]));

  function automatic int kof(input int idx);
    return (idx == 0) ? 8 : ((idx == 1) ? 2 : 1);
  endfunction

  // Reference: {bout, ovf, diff} of x - y - bi.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] full;
    logic [7:0] d;
    logic       o;
    full = {1'b0, x} - {1'b0, y} - {8'd0, bi};
    d    = full[7:0];
    o    = (x[7] != y[7]) && (d[7] != x[7]);
    return {full[8], o, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on build idx, checking latency, busy span, results
  // and the single-cycle done pulse. Operands are scrambled after capture.
  task automatic run_op(input int idx, input logic [7:0] x, input logic [7:0] y,
                        input logic bi, input logic [9:0] exp, input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    a = x; b = y; bin = bi;
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    a = ~x; b = ~y; bin = ~bi;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int c = 1; c <= kof(idx) + 4 && !seen; c++) begin
      if (busy_v[idx]) busy_cnt++;
      tick();
      if (done_v[idx]) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    chk($sformatf("%s latency", tag), lat, kof(idx));
    chk($sformatf("%s busy_cycles", tag), busy_cnt, kof(idx));
    chk($sformatf("%s busy_at_done", tag), {31'd0, busy_v[idx]}, 32'd0);
    chk($sformatf("%s diff", tag), {24'd0, diff_v[idx]}, {24'd0, exp[7:0]});
    chk($sformatf("%s bout", tag), {31'd0, bout_v[idx]}, {31'd0, exp[9]});
    chk($sformatf("%s ovf", tag), {31'd0, ovf_v[idx]}, {31'd0, exp[8]});
    tick();
    chk($sformatf("%s done_pulse", tag), {31'd0, done_v[idx]}, 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int done_cnt;
    int t1;
    int t2;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       bo2;
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rb;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, diff: 8'h1E, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, diff: 8'h80, bout: 1'b1, ovf: 1'b1};

    rst_n = 1'b0; start_v = 3'b000; a = 8'h00; b = 8'h00; bin = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset busy[%0d]", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("reset done[%0d]", i), {31'd0, done_v[i]}, 32'd0);
      chk($sformatf("reset diff[%0d]", i), {24'd0, diff_v[i]}, 32'd0);
      chk($sformatf("reset bout[%0d]", i), {31'd0, bout_v[i]}, 32'd0);
      chk($sformatf("reset ovf[%0d]", i), {31'd0, ovf_v[i]}, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Directed table across all three builds.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 3; i++) begin
        run_op(i, vecs[v].a, vecs[v].b, vecs[v].bin,
               {vecs[v].bout, vecs[v].ovf, vecs[v].diff}, $sformatf("vec%0d/d%0d", v, kof(i)));
      end
    end

    // Second start during RUN cycle 3 must be ignored.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'h00; bin = 1'b1; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    done_cnt = 0; t1 = 0; d1 = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done_v[0]) begin
        done_cnt++;
        t1 = c;
        d1 = diff_v[0];
      end
    end
    chk("ignore_start done_count", done_cnt, 1);
    chk("ignore_start done_time", t1, 5);
    chk("ignore_start diff", {24'd0, d1}, 32'h1E);

    // start held high through DONE: back-to-back, done pulses 9 apart.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start_v[0] = 1'b1;
    tick();
    done_cnt = 0; t1 = 0; t2 = 0; d1 = 8'h00; d2 = 8'h00; bo2 = 1'b0;
    for (int c = 1; c <= 25 && done_cnt < 2; c++) begin
      tick();
      if (done_v[0]) begin
        done_cnt++;
        if (done_cnt == 1) begin
          t1 = c; d1 = diff_v[0];
          a = 8'h00; b = 8'h01; bin = 1'b0;
        end else begin
          t2 = c; d2 = diff_v[0]; bo2 = bout_v[0];
          start_v[0] = 1'b0;
        end
      end
    end
    start_v[0] = 1'b0;
    chk("b2b first_time", t1, 8);
    chk("b2b spacing", t2 - t1, 9);
    chk("b2b first_diff", {24'd0, d1}, 32'h1E);
    chk("b2b second_diff", {24'd0, d2}, 32'hFF);
    chk("b2b second_bout", {31'd0, bo2}, 32'd1);
    tick();
    tick();

    // Reset at RUN cycle 4 abandons the operation.
    a = 8'h80; b = 8'h01; bin = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset busy", {31'd0, busy_v[0]}, 32'd0);
    chk("midreset done", {31'd0, done_v[0]}, 32'd0);
    chk("midreset diff", {24'd0, diff_v[0]}, 32'd0);
    chk("midreset bout", {31'd0, bout_v[0]}, 32'd0);
    chk("midreset ovf", {31'd0, ovf_v[0]}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_v[0] || busy_v[0]) done_cnt++;
    end
    chk("midreset no_activity", done_cnt, 0);

    // start together with reset is lost.
    a = 8'h5A; b = 8'h3C; rst_n = 1'b0; start_v[0] = 1'b1;
    tick();
    rst_n = 1'b1; start_v[0] = 1'b0;
    chk("start_in_reset busy0", {31'd0, busy_v[0]}, 32'd0);
    tick();
    chk("start_in_reset busy1", {31'd0, busy_v[0]}, 32'd0);

    run_op(0, 8'h80, 8'h01, 1'b0, {1'b0, 1'b1, 8'h7F}, "after_reset");

    // Random sweep against the reference model.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < ((i == 0) ? 100 : 1000); n++) begin
        rx = 8'($urandom);
        ry = 8'($urandom);
        rb = 1'($urandom);
        run_op(i, rx, ry, rb, model(rx, ry, rb), $sformatf("rnd%0d/d%0d %h-%h-%0d", n, kof(i), rx, ry, rb));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
